// File: rtl/fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader
//
// Reads a burst of `len` words from a show-ahead FIFO and forwards them on a
// valid/ready stream. A 2-entry skid buffer sits between the FIFO and the
// stream, so the FIFO side never depends on m_ready and the block sustains one
// word per cycle while keeping m_data registered.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   start, len             single-cycle burst request and its word count
//   busy, done             burst in progress / one-cycle completion pulse
//   fifo_empty, fifo_dout  FIFO status and show-ahead head word
//   fifo_rd_en             FIFO pop request (pop when fifo_empty is low)
//   m_data, m_valid,
//   m_ready, m_last        output stream, m_last marks the final burst word
// -----------------------------------------------------------------------------
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                state_q,     state_d;
    logic [LEN_WIDTH-1:0]  pop_left_q,  pop_left_d;
    logic [LEN_WIDTH-1:0]  out_left_q,  out_left_d;
    logic [1:0]            buf_count_q, buf_count_d;
    // buf0 is always the oldest entry and drives m_data directly.
    logic [DATA_WIDTH-1:0] buf0_q,      buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q,      buf1_d;

    logic pop;
    logic xfer;

    // Pop only while words are still owed and the buffer has room; m_ready is
    // deliberately absent so the FIFO handshake has no path from downstream.
    assign fifo_rd_en = (state_q == S_READ) && !fifo_empty && (buf_count_q < 2'd2);
    assign pop        = fifo_rd_en;
    assign xfer       = m_valid && m_ready;

    assign m_valid = (buf_count_q != 2'd0);
    assign m_data  = buf0_q;
    assign m_last  = m_valid && (out_left_q == LEN_WIDTH'(1));
    assign busy    = (state_q == S_READ) || (state_q == S_DRAIN);
    assign done    = (state_q == S_DONE);

    // NOTE: every signal written here gets its default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        pop_left_d  = pop_left_q;
        out_left_d  = out_left_q;
        buf_count_d = buf_count_q;
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;

        // Counters saturate at zero rather than wrap.
        if (pop && (pop_left_q != '0)) begin
            pop_left_d = pop_left_q - LEN_WIDTH'(1);
        end
        if (xfer && (out_left_q != '0)) begin
            out_left_d = out_left_q - LEN_WIDTH'(1);
        end

        // Skid buffer. On a simultaneous pop and transfer the new word goes
        // behind whatever survives the transfer, keeping order and count.
        unique case ({pop, xfer})
            2'b10: begin
                if (buf_count_q == 2'd0) begin
                    buf0_d = fifo_dout;
                end else begin
                    buf1_d = fifo_dout;
                end
                buf_count_d = buf_count_q + 2'd1;
            end
            2'b01: begin
                buf0_d      = buf1_q;
                buf_count_d = buf_count_q - 2'd1;
            end
            2'b11: begin
                if (buf_count_q == 2'd1) begin
                    buf0_d = fifo_dout;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = fifo_dout;
                end
            end
            default: ;
        endcase

        unique case (state_q)
            S_IDLE: begin
                if (start && (len != '0)) begin
                    pop_left_d = len;
                    out_left_d = len;
                    state_d    = S_READ;
                end
            end
            S_READ: begin
                if (pop && (pop_left_q == LEN_WIDTH'(1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (xfer && (out_left_q == LEN_WIDTH'(1))) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: the data registers are reset as well as the control state, so that
    // m_data reads as zero during reset and never exposes a word from an
    // aborted burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pop_left_q  <= '0;
            out_left_q  <= '0;
            buf_count_q <= 2'd0;
            buf0_q      <= '0;
            buf1_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above.
            state_q     <= state_d;
            pop_left_q  <= pop_left_d;
            out_left_q  <= out_left_d;
            buf_count_q <= buf_count_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;

    localparam int BOUND = 2000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] len;
    logic       busy;
    logic       done;
    logic       fifo_empty;
    logic [7:0] fifo_dout;
    logic       fifo_rd_en;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;

    always #5 clk = ~clk;

    fifo_burst_reader #(.DATA_WIDTH(8), .LEN_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last)
    );

    // Show-ahead FIFO model: pushes from the stimulus, pops on DUT request.
    logic [7:0] mem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pop_n  = 0;
    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_dout  = mem[rd_ptr[9:0]];

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            rd_ptr <= rd_ptr + 1;
            pop_n  <= pop_n + 1;
        end
    end

    // Stream monitor: logs every transfer and every done pulse.
    logic [7:0] out_data [0:1023];
    logic       out_last [0:1023];
    int out_n  = 0;
    int done_n = 0;

    always @(posedge clk) begin
        if (m_valid && m_ready) begin
            out_data[out_n[9:0]] <= m_data;
            out_last[out_n[9:0]] <= m_last;
            out_n <= out_n + 1;
        end
        if (done) done_n <= done_n + 1;
    end

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        mem[wr_ptr[9:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    // Pulse start for one edge, leaving the bench on the following negedge.
    task automatic pulse_start(input logic [7:0] l);
        @(negedge clk);
        start = 1'b1;
        len   = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count negedges until done is seen, then confirm it lasts one cycle.
    task automatic wait_done(input string tag, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
        check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    // Compare logged transfers from index `first` against exp_q.
    task automatic check_words(input string tag, input int first);
        check({tag, "_count"}, out_n - first, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < out_n - first; i++) begin
            check($sformatf("%s_data%0d", tag, i), {24'd0, out_data[first + i]}, {24'd0, exp_q[i]});
            check($sformatf("%s_last%0d", tag, i), {31'd0, out_last[first + i]},
                  {31'd0, (i == exp_q.size() - 1)});
        end
    endtask

    typedef struct {
        logic [7:0] len;
        logic [7:0] base;
        int         exp_cycles;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int cyc;
        int o0;
        int p0;
        int d0;
        int bad;

        // len words pre-filled, m_ready=1: one word per cycle, done len+1
        // edges after the start edge.
        vecs[0] = '{len: 8'd3,   base: 8'h11, exp_cycles: 4};
        vecs[1] = '{len: 8'd1,   base: 8'hA0, exp_cycles: 2};
        vecs[2] = '{len: 8'd5,   base: 8'h50, exp_cycles: 6};
        vecs[3] = '{len: 8'd255, base: 8'h00, exp_cycles: 256};

        rst_n   = 1'b0;
        start   = 1'b0;
        len     = 8'd0;
        m_ready = 1'b1;

        // Reset state
        #2;
        check("rst_fifo_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        check("rst_m_valid",    {31'd0, m_valid},    32'd0);
        check("rst_m_last",     {31'd0, m_last},     32'd0);
        check("rst_busy",       {31'd0, busy},       32'd0);
        check("rst_done",       {31'd0, done},       32'd0);
        check("rst_m_data",     {24'd0, m_data},     32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table-driven bursts, first entry is the 0x11/0x22/0x33 case.
        for (int v = 0; v < 4; v++) begin
            exp_q.delete();
            for (int i = 0; i < vecs[v].len; i++) begin
                push(vecs[v].base + 8'(i));
                exp_q.push_back(vecs[v].base + 8'(i));
            end
            o0 = out_n;
            p0 = pop_n;
            pulse_start(vecs[v].len);
            check($sformatf("vec%0d_busy", v), {31'd0, busy}, 32'd1);
            wait_done($sformatf("vec%0d", v), cyc);
            check($sformatf("vec%0d_cycles", v), cyc, vecs[v].exp_cycles);
            check($sformatf("vec%0d_pops", v), pop_n - p0, {24'd0, vecs[v].len});
            check_words($sformatf("vec%0d", v), o0);
        end

        // Short burst leaves residual words for the next burst.
        for (int i = 0; i < 5; i++) push(8'h61 + 8'(i));
        o0 = out_n;
        p0 = pop_n;
        pulse_start(8'd2);
        wait_done("resid_a", cyc);
        check("resid_a_pops", pop_n - p0, 2);
        check("resid_a_left", wr_ptr - rd_ptr, 3);
        exp_q = '{8'h61, 8'h62};
        check_words("resid_a", o0);
        o0 = out_n;
        pulse_start(8'd3);
        wait_done("resid_b", cyc);
        exp_q = '{8'h63, 8'h64, 8'h65};
        check_words("resid_b", o0);

        // Backpressure: buffer fills at two words and m_data holds.
        for (int i = 0; i < 4; i++) push(8'h71 + 8'(i));
        o0 = out_n;
        p0 = pop_n;
        m_ready = 1'b0;
        pulse_start(8'd4);
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (m_valid !== 1'b1 || m_data !== 8'h71) bad++;
        end
        check("bp_data_stable", bad, 0);
        check("bp_pops", pop_n - p0, 2);
        check("bp_rd_en_low", {31'd0, fifo_rd_en}, 32'd0);
        m_ready = 1'b1;
        wait_done("bp", cyc);
        exp_q = '{8'h71, 8'h72, 8'h73, 8'h74};
        check_words("bp", o0);

        // Empty FIFO: wait without popping, then resume as words arrive.
        o0 = out_n;
        p0 = pop_n;
        pulse_start(8'd2);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy !== 1'b1 || fifo_rd_en !== 1'b0) bad++;
        end
        check("empty_wait", bad, 0);
        check("empty_no_pops", pop_n - p0, 0);
        push(8'h81);
        @(negedge clk);
        check("empty_first_valid", {31'd0, m_valid}, 32'd1);
        check("empty_first_data", {24'd0, m_data}, 32'h81);
        check("empty_busy_mid", {31'd0, busy}, 32'd1);
        push(8'h82);
        wait_done("empty", cyc);
        exp_q = '{8'h81, 8'h82};
        check_words("empty", o0);

        // len==0 and start while busy are both ignored.
        push(8'h91);
        push(8'h92);
        p0 = pop_n;
        d0 = done_n;
        pulse_start(8'd0);
        repeat (3) @(negedge clk);
        check("len0_busy", {31'd0, busy}, 32'd0);
        check("len0_pops", pop_n - p0, 0);
        check("len0_done", done_n - d0, 0);
        o0 = out_n;
        m_ready = 1'b0;
        pulse_start(8'd1);
        @(negedge clk);
        pulse_start(8'd5);
        repeat (2) @(negedge clk);
        check("busy_start_pops", pop_n - p0, 1);
        m_ready = 1'b1;
        wait_done("busy_start", cyc);
        exp_q = '{8'h91};
        check_words("busy_start", o0);
        check("busy_start_left", wr_ptr - rd_ptr, 1);

        // Reset mid-burst with a full buffer.
        for (int i = 0; i < 4; i++) push(8'hA1 + 8'(i));
        d0 = done_n;
        m_ready = 1'b0;
        pulse_start(8'd4);
        repeat (2) @(negedge clk);
        check("mid_pre_valid", {31'd0, m_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_m_valid", {31'd0, m_valid},    32'd0);
        check("mid_rst_busy",    {31'd0, busy},       32'd0);
        check("mid_rst_rd_en",   {31'd0, fifo_rd_en}, 32'd0);
        check("mid_rst_m_data",  {24'd0, m_data},     32'd0);
        @(negedge clk);
        check("mid_rst_no_done", done_n - d0, 0);
        check("mid_rst_left", wr_ptr - rd_ptr, 3);
        // Start presented together with release: taken on the first edge.
        m_ready = 1'b1;
        rst_n   = 1'b1;
        start   = 1'b1;
        len     = 8'd3;
        o0 = out_n;
        @(negedge clk);
        start = 1'b0;
        check("post_rst_busy", {31'd0, busy}, 32'd1);
        wait_done("post_rst", cyc);
        exp_q = '{8'hA2, 8'hA3, 8'hA4};
        check_words("post_rst", o0);
        check("post_rst_left", wr_ptr - rd_ptr, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
